pixel_window_cache: RTL and testbench
=====================================

Name: pixel_window_cache

Overview:
- Parametrised multi-channel sliding-window pixel buffer for the image datapath; feeds a WIN_PIX-wide pixel window per colour channel to the filter stage.
- Each channel is a pixel queue loaded one word (WORD_PIX pixels) at a time and advanced one pixel per shift.
- Adds over the previous fixed 3-channel cache:
  - parametrised channels, pixel width, window width and depth
  - per-channel fill tracking with ready/valid handshakes
  - window-valid flag, synchronous flush, and defined simultaneous write+shift.

Parameters:
- CHANNELS, 3: number of colour channels.
- PIX_W, 8: bits per pixel.
- WORD_PIX, 2: pixels per write word.
- WIN_PIX, 3: pixels per output window; must satisfy WIN_PIX <= BUF_PIX - WORD_PIX.
- DEPTH_WORDS, 3: buffer depth in words per channel; BUF_PIX = DEPTH_WORDS*WORD_PIX.
- CH_W, max(1,$clog2(CHANNELS)): width of the channel select.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of all channels.
- wr_valid  in  1  write request.
- wr_ch  in  CH_W  target channel for the write.
- wr_data  in  WORD_PIX*PIX_W  word; MSB pixel is the oldest.
- wr_ready  out  1  selected channel can accept a word.
- sh_valid  in  1  shift request, applies to all channels.
- sh_ready  out  1  shift permitted.
- win_out  out  CHANNELS*WIN_PIX*PIX_W  windows.
  - Channel c occupies slice [(c+1)*WIN_PIX*PIX_W-1 : c*WIN_PIX*PIX_W].
  - Within a slice, pixel 0 (oldest) is in the MSBs.
- win_valid  out  1  win_out holds a full window in every channel.

Behaviour:
- Per-channel state:
  - pixel array buf[0..BUF_PIX-1], where buf[0] is the oldest pixel.
  - count, range 0..BUF_PIX.
- Reset (rst=0, async): all buf = 0, all count = 0, win_out = 0, win_valid = 0. Asserting reset mid-operation discards all contents immediately.
- wr_ready (combinational):
  - = (count[wr_ch] <= BUF_PIX-WORD_PIX) and (wr_ch < CHANNELS).
  - Out-of-range wr_ch gives wr_ready = 0; the write is ignored.
- sh_ready (combinational): = every channel has count > WIN_PIX, so a full window remains after the shift.
- Write accepted on wr_valid & wr_ready & ~flush:
  - Word pixels are appended at buf[count..count+WORD_PIX-1] in MSB-first order.
  - count += WORD_PIX.
- Shift accepted on sh_valid & sh_ready & ~flush, in every channel:
  - buf[i] <= buf[i+1].
  - buf[BUF_PIX-1] <= 0.
  - count -= 1.
- Write and shift in the same cycle:
  - Shift is applied first; the word is appended at position count-1 of the written channel.
  - That channel's net count change is WORD_PIX-1.
  - wr_ready is evaluated on the pre-shift count (conservative).
- flush=1:
  - Highest priority after reset; write and shift are ignored that cycle.
  - Next cycle: all count = 0 and all buf = 0; win_valid = 0 from the following edge.
- Non-accepted requests (valid without ready) change no state. Requesters hold their request until ready.
- Output register, updated every edge:
  - win_out <= pre-update buf[0..WIN_PIX-1] of each channel.
  - Pixels at index >= count read as 0.
  - win_valid <= pre-update (all counts >= WIN_PIX).
  - Latency: state change at edge t is visible on win_out after edge t+1.
- Boundaries:
  - count never exceeds BUF_PIX and never goes below 0; no wrap-around.
  - A full channel stalls only writes to that channel.
  - A channel with fewer than WIN_PIX+1 pixels stalls all shifts.

Test Plan:
- Reset/idle: rst=0 then release, defaults -> win_out=0, win_valid=0, wr_ready=1 for wr_ch 0..2, wr_ready=0 for wr_ch=3, sh_ready=0.
- Fill and window:
  - Stimulus: ch0 A1A2 then A3A4; ch1 B1B2, B3B4; ch2 C1C2, C3C4 (16-bit words).
  - Required: two edges after the last write, win_out = {C1C2C3, B1B2B3, A1A2A3} (24 bits each), win_valid=1, sh_ready=1 (count 4).
- Shift:
  - One sh_valid pulse from the state above -> windows A2A3A4 / B2B3B4 / C2C3C4; sh_ready=0 (count 3).
  - sh_valid held with sh_ready=0 -> no change.
- Full and overrun:
  - Three writes to ch0 (11 22, 33 44, 55 66) -> count 6, wr_ready=0.
  - Fourth write 7788 is refused; window stays 11 22 33 after further writes.
- Simultaneous write+shift:
  - Start: all channels at count 4.
  - Stimulus: shift plus ch0 write DEDF in one cycle.
  - Required: ch0 count 5, buf = A2 A3 A4 DE DF; ch1/ch2 count 3.
- Flush and async reset:
  - flush together with wr_valid & sh_valid -> all counts 0, win_valid=0 two edges later, and the write and shift are dropped.
  - rst pulsed between edges mid-fill -> outputs clear without a clock edge.

Source files
------------

// File: rtl/pixel_window_cache.sv
// Multi-channel sliding-window pixel buffer: word-wide appends per channel, one-pixel
// shifts across all channels, and a registered WIN_PIX window per channel.
module pixel_window_cache #(
    parameter int CHANNELS    = 3,
    parameter int PIX_W       = 8,
    parameter int WORD_PIX    = 2,
    parameter int WIN_PIX     = 3,
    parameter int DEPTH_WORDS = 3,
    parameter int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_i,
    input  logic                              wr_valid_i,
    input  logic [CH_W-1:0]                   wr_ch_i,
    input  logic [WORD_PIX*PIX_W-1:0]         wr_data_i,
    output logic                              wr_ready_o,
    input  logic                              sh_valid_i,
    output logic                              sh_ready_o,
    output logic [CHANNELS*WIN_PIX*PIX_W-1:0] win_out_o,
    output logic                              win_valid_o
);
    localparam int BUF_PIX = DEPTH_WORDS * WORD_PIX;
    localparam int CNT_W   = $clog2(BUF_PIX + 1);
    localparam int WIN_W   = WIN_PIX * PIX_W;
    localparam logic [CNT_W-1:0] WR_LIM  = CNT_W'(BUF_PIX - WORD_PIX);
    localparam logic [CNT_W-1:0] WIN_LIM = CNT_W'(WIN_PIX);
    localparam logic [CH_W:0]    NCH     = (CH_W + 1)'(CHANNELS);

    logic [CHANNELS-1:0][BUF_PIX-1:0][PIX_W-1:0] pix_q, pix_d;
    logic [CHANNELS-1:0][CNT_W-1:0]              cnt_q, cnt_d, sh_cnt;
    logic [CHANNELS*WIN_W-1:0]                   win_q, win_d;
    logic                                        win_vld_q, win_vld_d;
    logic [WORD_PIX-1:0][PIX_W-1:0]              wr_pix;
    logic [CHANNELS-1:0]                         wr_sel;
    logic [CNT_W-1:0]                            wr_cnt;
    logic                                        do_wr, do_sh;

    // Handshake readiness; wr_ready uses the pre-shift count of the selected channel.
    always_comb begin
        wr_cnt     = '0;
        sh_ready_o = 1'b1;
        win_vld_d  = 1'b1;
        for (int c = 0; c < CHANNELS; c++) begin
            if (wr_ch_i == CH_W'(c)) wr_cnt = cnt_q[c];
            if (cnt_q[c] <= WIN_LIM) sh_ready_o = 1'b0;
            if (cnt_q[c] < WIN_LIM)  win_vld_d  = 1'b0;
        end
        wr_ready_o = ({1'b0, wr_ch_i} < NCH) && (wr_cnt <= WR_LIM);
    end

    assign do_wr = wr_valid_i && wr_ready_o && !flush_i;
    assign do_sh = sh_valid_i && sh_ready_o && !flush_i;

    always_comb begin
        for (int k = 0; k < WORD_PIX; k++)
            wr_pix[k] = wr_data_i[(WORD_PIX-1-k)*PIX_W +: PIX_W];
        for (int c = 0; c < CHANNELS; c++)
            wr_sel[c] = do_wr && (wr_ch_i == CH_W'(c));
    end

    // Shift first, then append the word behind the post-shift tail.
    always_comb begin
        pix_d  = pix_q;
        cnt_d  = cnt_q;
        sh_cnt = cnt_q;
        for (int c = 0; c < CHANNELS; c++) begin
            if (do_sh) begin
                pix_d[c]  = pix_q[c] >> PIX_W;
                sh_cnt[c] = cnt_q[c] - CNT_W'(1);
            end
            cnt_d[c] = sh_cnt[c];
            if (wr_sel[c]) begin
                for (int i = 0; i < BUF_PIX; i++)
                    for (int k = 0; k < WORD_PIX; k++)
                        if (CNT_W'(i) == sh_cnt[c] + CNT_W'(k)) pix_d[c][i] = wr_pix[k];
                cnt_d[c] = sh_cnt[c] + CNT_W'(WORD_PIX);
            end
            if (flush_i) begin
                pix_d[c] = '0;
                cnt_d[c] = '0;
            end
        end
    end

    // Window from pre-update state; slots beyond the fill level read as zero.
    always_comb begin
        win_d = '0;
        for (int c = 0; c < CHANNELS; c++)
            for (int p = 0; p < WIN_PIX; p++)
                if (CNT_W'(p) < cnt_q[c])
                    win_d[c*WIN_W + (WIN_PIX-1-p)*PIX_W +: PIX_W] = pix_q[c][p];
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            pix_q     <= '0;
            cnt_q     <= '0;
            win_q     <= '0;
            win_vld_q <= 1'b0;
        end else begin
            pix_q     <= pix_d;
            cnt_q     <= cnt_d;
            win_q     <= win_d;
            win_vld_q <= win_vld_d;
        end
    end

    assign win_out_o   = win_q;
    assign win_valid_o = win_vld_q;
endmodule

// File: tb/tb_pixel_window_cache.sv
// Bench for pixel_window_cache: queue-based channel model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_pixel_window_cache;
    localparam int CH = 3, PW = 8, WP = 2, WIN = 3, DW = 3, BUFP = DW * WP;

    logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, wr_valid = 1'b0, sh_valid = 1'b0;
    logic [1:0]  wr_ch = '0;
    logic [15:0] wr_data = '0;
    logic        wr_ready, sh_ready, win_valid;
    logic [71:0] win_out;

    int tests = 0, fails = 0;
    logic [7:0]  mq [CH][$];
    logic [71:0] exp_win = '0;
    logic        exp_vld = 1'b0;

    pixel_window_cache #(.CHANNELS(CH), .PIX_W(PW), .WORD_PIX(WP), .WIN_PIX(WIN),
                         .DEPTH_WORDS(DW), .CH_W(2)) dut (
        .clk_i(clk), .rst_i(rst_n), .flush_i(flush), .wr_valid_i(wr_valid),
        .wr_ch_i(wr_ch), .wr_data_i(wr_data), .wr_ready_o(wr_ready),
        .sh_valid_i(sh_valid), .sh_ready_o(sh_ready),
        .win_out_o(win_out), .win_valid_o(win_valid));

    always #5 clk = ~clk;

    function automatic logic m_wr_rdy();
        if (int'(wr_ch) >= CH) return 1'b0;
        return mq[int'(wr_ch)].size() <= BUFP - WP;
    endfunction

    function automatic logic m_sh_rdy();
        for (int c = 0; c < CH; c++) if (mq[c].size() <= WIN) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic m_vld();
        for (int c = 0; c < CH; c++) if (mq[c].size() < WIN) return 1'b0;
        return 1'b1;
    endfunction

    function automatic logic [71:0] m_win();
        logic [71:0] w = '0;
        for (int c = 0; c < CH; c++)
            for (int p = 0; p < WIN; p++)
                if (p < mq[c].size()) w[c*24 + (WIN-1-p)*8 +: 8] = mq[c][p];
        return w;
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic m_clear();
        for (int c = 0; c < CH; c++) mq[c].delete();
    endtask

    // One clock: check handshakes, advance the model, check registered outputs.
    task automatic cycle();
        logic [71:0] nw;
        logic nv, wr, sh;
        #1;
        chk("wr_ready", wr_ready, m_wr_rdy());
        chk("sh_ready", sh_ready, m_sh_rdy());
        nw = m_win();
        nv = m_vld();
        wr = wr_valid && m_wr_rdy();
        sh = sh_valid && m_sh_rdy();
        if (flush) m_clear();
        else begin
            if (sh) for (int c = 0; c < CH; c++) void'(mq[c].pop_front());
            if (wr) begin
                mq[int'(wr_ch)].push_back(wr_data[15:8]);
                mq[int'(wr_ch)].push_back(wr_data[7:0]);
            end
        end
        exp_win = nw;
        exp_vld = nv;
        @(posedge clk);
        @(negedge clk);
        chk("win_out", win_out, exp_win);
        chk("win_valid", win_valid, exp_vld);
    endtask

    task automatic wr(input int ch, input logic [15:0] d);
        wr_valid = 1'b1; wr_ch = 2'(ch); wr_data = d;
        cycle();
        wr_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic fill_abc();
        wr(0, 16'hA1A2); wr(0, 16'hA3A4);
        wr(1, 16'hB1B2); wr(1, 16'hB3B4);
        wr(2, 16'hC1C2); wr(2, 16'hC3C4);
    endtask

    initial begin
        logic [39:0] q0;
        // Reset state, with wr_ready probed for every channel select
        #3;
        chk("rst_win_out", win_out, 72'h0);
        chk("rst_win_valid", win_valid, 1'b0);
        chk("rst_sh_ready", sh_ready, 1'b0);
        for (int c = 0; c < 4; c++) begin
            wr_ch = 2'(c); #1;
            chk($sformatf("rst_wr_ready_ch%0d", c), wr_ready, (c < 3) ? 1'b1 : 1'b0);
        end
        wr_ch = '0;
        @(negedge clk); rst_n = 1'b1;

        // Fill and window
        fill_abc();
        idle(1);
        chk("fill_window", win_out, 72'hC1C2C3_B1B2B3_A1A2A3);
        chk("fill_valid", win_valid, 1'b1);
        chk("fill_sh_ready", sh_ready, 1'b1);

        // Single shift, then a held shift that is never ready
        sh_valid = 1'b1; cycle(); sh_valid = 1'b0;
        idle(1);
        chk("shift_window", win_out, 72'hC2C3C4_B2B3B4_A2A3A4);
        chk("shift_sh_ready", sh_ready, 1'b0);
        sh_valid = 1'b1; idle(2); sh_valid = 1'b0;
        chk("held_shift_window", win_out, 72'hC2C3C4_B2B3B4_A2A3A4);

        // Flush drops a concurrent write and shift
        flush = 1'b1; wr_valid = 1'b1; wr_ch = 2'd0; wr_data = 16'hEEEE; sh_valid = 1'b1;
        cycle();
        flush = 1'b0; wr_valid = 1'b0; sh_valid = 1'b0;
        idle(1);
        chk("flush_window", win_out, 72'h0);
        chk("flush_valid", win_valid, 1'b0);

        // Simultaneous write+shift from count 4
        fill_abc();
        idle(1);
        sh_valid = 1'b1; wr_valid = 1'b1; wr_ch = 2'd0; wr_data = 16'hDEDF;
        cycle();
        sh_valid = 1'b0; wr_valid = 1'b0;
        idle(1);
        chk("ws_window", win_out, 72'hC2C3C4_B2B3B4_A2A3A4);
        q0 = '0;
        for (int i = 0; i < mq[0].size() && i < 5; i++) q0[(4-i)*8 +: 8] = mq[0][i];
        chk("ws_model_ch0", q0, 40'hA2A3A4DEDF);
        chk("ws_model_counts", {8'(mq[0].size()), 8'(mq[1].size()), 8'(mq[2].size())}, 24'h050303);
        wr_ch = 2'd0; #1; chk("ws_wr_ready_ch0", wr_ready, 1'b0);
        wr_ch = 2'd1; #1; chk("ws_wr_ready_ch1", wr_ready, 1'b1);
        @(negedge clk);

        // Full channel and overrun
        flush = 1'b1; cycle(); flush = 1'b0;
        wr(0, 16'h1122); wr(0, 16'h3344); wr(0, 16'h5566);
        wr_ch = 2'd0; #1; chk("full_wr_ready", wr_ready, 1'b0);
        wr_valid = 1'b1; wr_data = 16'h7788; idle(3); wr_valid = 1'b0;
        idle(1);
        chk("full_window", win_out, 72'h112233);
        chk("full_model_count", 8'(mq[0].size()), 8'd6);

        // Randomized traffic
        for (int n = 0; n < 800; n++) begin
            flush    = ($urandom_range(0, 39) == 0);
            wr_valid = ($urandom_range(0, 2) != 0);
            wr_ch    = 2'($urandom_range(0, 3));
            wr_data  = 16'($urandom);
            sh_valid = ($urandom_range(0, 2) == 0);
            cycle();
        end
        flush = 1'b0; wr_valid = 1'b0; sh_valid = 1'b0;

        // Asynchronous reset between edges mid-fill
        fill_abc();
        idle(1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_win_out", win_out, 72'h0);
        chk("async_rst_valid", win_valid, 1'b0);
        m_clear();
        exp_win = '0;
        exp_vld = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        idle(2);
        wr(1, 16'h0102); wr(1, 16'h0304);
        idle(1);
        chk("post_rst_window", win_out, 72'h010203_000000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
